// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter:
//   - parity-mode constants PAR_NONE / PAR_EVEN / PAR_ODD
//   - 3-bit transmitter state encoding IDLE / START / DATA / PARITY / STOP
//   - frame_ticks(): frame length in s_tick pulses, for benches and
//     higher-level timing calculations
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Number of s_tick pulses from the start of the start bit to the end of
  // the last stop bit.
  function automatic int frame_ticks(input int data_bits, input int parity,
                                     input int stop_bits, input int sb_tick);
    return sb_tick * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity bit, STOP_BITS stop bits. Bit timing is taken
// from an external oversampling tick (SB_TICK ticks per bit).
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   s_tick    oversampling tick, one clk cycle wide
//   tx_valid  data_in holds a character to send
//   tx_ready  high only in IDLE; transfer on tx_valid && tx_ready
//   data_in   character, captured on transfer
//   tx        registered serial line, idles high
//   tx_busy   high from the cycle after transfer to the end of the frame
//   tx_done   one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] D_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] P_LAST = NW'(STOP_BITS - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  // Illegal parameter combinations stop elaboration.
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (SB_TICK < 8 || SB_TICK > 32) begin : g_bad_sb_tick
    $error("uart_tx_cfg: SB_TICK must be in 8..32");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  // Parity of the latched character; odd parity is the inverted XOR-reduce.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    calc_parity = (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  state_t                state_r;
  logic [SW-1:0]         s_cnt_r;
  logic [NW-1:0]         n_cnt_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic                  par_r;
  logic                  bit_end_s;

  // A bit period ends on the tick that completes SB_TICK ticks.
  assign bit_end_s = s_tick && (s_cnt_r == S_LAST);

  // Transmit FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      s_cnt_r  <= '0;
      n_cnt_r  <= '0;
      shift_r  <= '0;
      par_r    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // Tick counter runs in every frame state and wraps at each bit end.
      if (state_r != IDLE && s_tick) begin
        s_cnt_r <= bit_end_s ? '0 : (s_cnt_r + S_ONE);
      end

      case (state_r)
        IDLE: begin
          s_cnt_r <= '0;
          n_cnt_r <= '0;
          if (tx_valid && tx_ready) begin
            shift_r  <= data_in;
            par_r    <= calc_parity(data_in);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state_r  <= START;
          end else begin
            // After a frame, ready rises one cycle after the done pulse.
            tx       <= 1'b1;
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_end_s) begin
            tx      <= shift_r[0];
            state_r <= DATA;
          end
        end

        DATA: begin
          if (bit_end_s) begin
            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
            if (n_cnt_r == D_LAST) begin
              n_cnt_r <= '0;
              if (PARITY == PAR_NONE) begin
                tx      <= 1'b1;
                state_r <= STOP;
              end else begin
                tx      <= par_r;
                state_r <= uart_pkg::PARITY;
              end
            end else begin
              n_cnt_r <= n_cnt_r + N_ONE;
              // Next bit is what becomes shift_r[0] after this shift.
              tx      <= shift_r[1];
            end
          end
        end

        uart_pkg::PARITY: begin
          if (bit_end_s) begin
            tx      <= 1'b1;
            state_r <= STOP;
          end
        end

        STOP: begin
          if (bit_end_s) begin
            if (n_cnt_r == P_LAST) begin
              n_cnt_r <= '0;
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state_r <= IDLE;
            end else begin
              n_cnt_r <= n_cnt_r + N_ONE;
            end
          end
        end

        default: begin
          state_r  <= IDLE;
          s_cnt_r  <= '0;
          n_cnt_r  <= '0;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
